// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: control-unit <-> datapath bundle; master is the sequencer, slave the datapath side.
interface cpu_control_unit_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             step;
    logic [3:0]       IRCU;
    logic [7:0]       Ans;
    logic             A_select;
    logic             B_select;
    logic             Aload;
    logic             Bload;
    logic             ANSload;
    logic [1:0]       select_mode;
    logic             IRload;
    logic             PCload;
    logic [1:0]       JSM;
    logic             busy;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  start, step, IRCU, Ans,
        output A_select, B_select, Aload, Bload, ANSload, select_mode,
               IRload, PCload, JSM, busy, halted, illegal, instr_count
    );

    modport slave (
        output start, step, IRCU, Ans,
        input  A_select, B_select, Aload, Bload, ANSload, select_mode,
               IRload, PCload, JSM, busy, halted, illegal, instr_count
    );
endinterface

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/load/decode/execute sequencer for the 8-bit accumulator CPU.
// Define CU_SINGLE_STEP_EN to park in STEPWAIT after every non-HLT instruction until step is raised.
module cpu_control_unit #(
    parameter int ROM_WAIT = 1,
    parameter int CNT_W    = 16
) (
    input logic                Clk,
    input logic                Reset,
    cpu_control_unit_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, DECODE, EXEC, HALT, STEPWAIT} state_t;

    state_t           state;
    state_t           exec_next;
    logic [2:0]       wait_cnt;
    logic [3:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] count_q;
    logic             in_exec;
    logic             take_jump;
    logic             take_mode;

`ifdef CU_SINGLE_STEP_EN
    assign exec_next = (op_q == 4'hF) ? HALT : STEPWAIT;
`else
    assign exec_next = (op_q == 4'hF) ? HALT : FETCH;
`endif

    // Sequencer state, ROM wait counter, latched opcode, sticky illegal flag and retire count
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            wait_cnt  <= 3'd0;
            op_q      <= 4'h0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            if (state != FETCH) wait_cnt <= 3'(ROM_WAIT - 1);
            case (state)
                IDLE, HALT: if (bus.start) state <= FETCH;
                FETCH: begin
                    if (wait_cnt == 3'd0) state <= LOAD;
                    else wait_cnt <= wait_cnt - 3'd1;
                end
                LOAD: state <= DECODE;
                DECODE: begin
                    op_q      <= bus.IRCU;
                    illegal_q <= illegal_q | (bus.IRCU inside {[4'hC:4'hE]});
                    state     <= EXEC;
                end
                EXEC: begin
                    if (count_q != '1) count_q <= count_q + 1'b1;
                    state <= exec_next;
                end
                STEPWAIT: if (bus.step) state <= FETCH;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath controls decoded from registered state and opcode; everything idles outside LOAD/EXEC
    always_comb begin
        in_exec         = state == EXEC;
        take_jump       = in_exec && (op_q == 4'h9 || (op_q == 4'hA && bus.Ans == 8'h00));
        take_mode       = in_exec && op_q == 4'hB;
        bus.A_select    = in_exec && op_q == 4'h7;
        bus.B_select    = in_exec && op_q == 4'h8;
        bus.Aload       = in_exec && (op_q == 4'h1 || op_q == 4'h7);
        bus.Bload       = in_exec && (op_q == 4'h2 || op_q == 4'h8);
        bus.ANSload     = in_exec && op_q inside {[4'h3:4'h6]};
        bus.select_mode = bus.ANSload ? op_q[1:0] + 2'd1 : 2'b00;
        bus.IRload      = state == LOAD;
        bus.PCload      = state == LOAD || take_jump || take_mode;
        bus.JSM         = take_jump ? 2'b01 : take_mode ? 2'b10 : 2'b00;
    end

    assign bus.busy        = state inside {FETCH, LOAD, DECODE, EXEC, STEPWAIT};
    assign bus.halted      = state == HALT;
    assign bus.illegal     = illegal_q;
    assign bus.instr_count = count_q;
endmodule
